// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional bne decode is enabled by defining MC_CTRL_BNE_EN.
module mips_mc_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC,
    S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_EX, S_ADDI_WB, S_ERR
  } state_t;

  state_t state_q, state_d;
  logic   is_sw_q, is_sw_d;
  logic   bne_q, bne_d;
  logic   illegal_q, illegal_d;
  logic   mem_read_s, mem_write_s, ir_write_s, pc_en_s, reg_write_s, instr_done_s;

  // {legal, alu_op} for an R-type funct field
  function automatic logic [3:0] funct_dec(input logic [5:0] f);
    case (f)
      6'b100000: funct_dec = 4'b1_010;
      6'b100010: funct_dec = 4'b1_110;
      6'b100100: funct_dec = 4'b1_000;
      6'b100101: funct_dec = 4'b1_001;
      6'b101010: funct_dec = 4'b1_111;
      default:   funct_dec = 4'b0_000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      is_sw_q   <= 1'b0;
      bne_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_sw_q   <= is_sw_d;
      bne_q     <= bne_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    is_sw_d      = is_sw_q;
    bne_d        = bne_q;
    i_or_d       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_en_s      = 1'b0;
    pc_src       = 2'b00;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_op       = 3'b000;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write_s  = 1'b0;
    instr_done_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_s = 1'b1;
        alu_src_b  = 2'b01;
        alu_op     = 3'b010;
        ir_write_s = mem_ready;
        pc_en_s    = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut
        alu_src_b = 2'b11;
        alu_op    = 3'b010;
        case (opcode)
          OP_RTYPE: state_d = funct_dec(funct)[3] ? S_EXEC : S_ERR;
          OP_LW:    begin state_d = S_MEM_ADDR; is_sw_d = 1'b0; end
          OP_SW:    begin state_d = S_MEM_ADDR; is_sw_d = 1'b1; end
          OP_BEQ:   begin state_d = S_BRANCH;   bne_d   = 1'b0; end
`ifdef MC_CTRL_BNE_EN
          OP_BNE:   begin state_d = S_BRANCH;   bne_d   = 1'b1; end
`endif
          OP_J:     state_d = S_JUMP;
          OP_ADDI:  state_d = S_ADDI_EX;
          default:  state_d = S_ERR;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
        state_d   = is_sw_q ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        i_or_d     = 1'b1;
        mem_read_s = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg   = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEM_WR: begin
        i_or_d       = 1'b1;
        mem_write_s  = 1'b1;
        instr_done_s = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = funct_dec(funct)[2:0];
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_dst      = 1'b1;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_op       = 3'b110;
        pc_src       = 2'b01;
        pc_en_s      = bne_q ? ~zero_flag : zero_flag;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pc_src       = 2'b10;
        pc_en_s      = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_FETCH;
    endcase
  end

  assign illegal_d = illegal_q | (state_d == S_ERR);
  assign illegal_op = illegal_q;

  // Strobes are killed the instant reset asserts, before the state register settles
  assign mem_read   = mem_read_s   & rst_n;
  assign mem_write  = mem_write_s  & rst_n;
  assign ir_write   = ir_write_s   & rst_n;
  assign pc_en      = pc_en_s      & rst_n;
  assign reg_write  = reg_write_s  & rst_n;
  assign instr_done = instr_done_s & rst_n;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: table-driven instruction vectors with a scoreboard, plus reset/illegal/bne sequences.
module tb_mips_mc_ctrl;
  logic       clk, rst_n;
  logic [5:0] opcode, funct;
  logic       zero_flag, mem_ready;
  logic       i_or_d, mem_read, mem_write, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a;
  logic [2:0] alu_op;
  logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op;

  mips_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // last = {reg_write, mem_to_reg, reg_dst, pc_en, pc_src[1:0], mem_write} on the done cycle
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    int         wstart;
    int         wn;
    int         alu_cyc;
    int         cycles;
    logic [2:0] alu3;
    logic [6:0] last;
    int         mrd;
  } vec_t;

  typedef struct {
    int         cycles;
    logic [2:0] alu3;
    logic [6:0] last;
    int         mrd;
  } exp_t;

  vec_t vecs[14];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t       e;
    int         mrd, cyc;
    logic       done;
    logic [2:0] alu_seen;
    logic [6:0] last;
    opcode    = v.op;
    funct     = v.fn;
    zero_flag = v.zero;
    sb_q.push_back('{v.cycles, v.alu3, v.last, v.mrd});
    mrd = 0; cyc = 0; done = 1'b0; alu_seen = 3'b000; last = 7'b0;
    for (int c = 1; c <= 30 && !done; c++) begin
      mem_ready = !(c >= v.wstart && c < v.wstart + v.wn);
      @(negedge clk);
      if (c == 1)
        chk($sformatf("fetch_entry[%0d]", idx),
            {mem_read, ir_write, pc_en, alu_src_b, alu_op, i_or_d},
            {1'b1, mem_ready, mem_ready, 2'b01, 3'b010, 1'b0});
      if (mem_read) mrd++;
      if (c == v.alu_cyc) alu_seen = alu_op;
      if (instr_done) begin
        done = 1'b1;
        cyc  = c;
        last = {reg_write, mem_to_reg, reg_dst, pc_en, pc_src, mem_write};
      end
      tick();
    end
    if (!done) begin
      chk($sformatf("timeout[%0d]", idx), 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      chk($sformatf("sb_empty[%0d]", idx), 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("cycles[%0d]", idx), cyc, e.cycles);
      chk($sformatf("alu_op[%0d]", idx), alu_seen, e.alu3);
      chk($sformatf("done_outs[%0d]", idx), last, e.last);
      chk($sformatf("mem_read_cnt[%0d]", idx), mrd, e.mrd);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_strobes", {mem_read, mem_write, ir_write, pc_en, reg_write, instr_done}, 6'b0);
    chk("rst_illegal", illegal_op, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_cyc;
    //          op         fn         z  ws wn ac cyc alu     last        mrd
    vecs[0]  = '{6'b000000, 6'b100000, 0, 0, 0, 3, 4, 3'b010, 7'b1010000, 1};
    vecs[1]  = '{6'b000000, 6'b100010, 0, 0, 0, 3, 4, 3'b110, 7'b1010000, 1};
    vecs[2]  = '{6'b000000, 6'b100100, 0, 0, 0, 3, 4, 3'b000, 7'b1010000, 1};
    vecs[3]  = '{6'b000000, 6'b100101, 0, 0, 0, 3, 4, 3'b001, 7'b1010000, 1};
    vecs[4]  = '{6'b000000, 6'b101010, 0, 0, 0, 3, 4, 3'b111, 7'b1010000, 1};
    vecs[5]  = '{6'b100011, 6'b000000, 0, 0, 0, 3, 5, 3'b010, 7'b1100000, 2};
    vecs[6]  = '{6'b100011, 6'b000000, 0, 4, 2, 3, 7, 3'b010, 7'b1100000, 4};
    vecs[7]  = '{6'b101011, 6'b000000, 0, 0, 0, 3, 4, 3'b010, 7'b0000001, 1};
    vecs[8]  = '{6'b101011, 6'b000000, 0, 4, 1, 3, 5, 3'b010, 7'b0000001, 1};
    vecs[9]  = '{6'b001000, 6'b000000, 0, 0, 0, 3, 4, 3'b010, 7'b1000000, 1};
    vecs[10] = '{6'b000100, 6'b000000, 1, 0, 0, 3, 3, 3'b110, 7'b0001010, 1};
    vecs[11] = '{6'b000100, 6'b000000, 0, 0, 0, 3, 3, 3'b110, 7'b0000010, 1};
    vecs[12] = '{6'b000010, 6'b000000, 0, 0, 0, 3, 3, 3'b000, 7'b0001100, 1};
    vecs[13] = '{6'b000000, 6'b100000, 0, 1, 2, 5, 6, 3'b010, 7'b1010000, 3};

    rst_n = 1'b0; opcode = 6'b0; funct = 6'b0; zero_flag = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_pc_ir", {pc_en, ir_write}, 2'b00);
    chk("rst_strobes0", {mem_read, mem_write, reg_write, instr_done}, 4'b0);
    chk("rst_selects", {alu_src_b, alu_op, i_or_d, alu_src_a, pc_src, reg_dst, mem_to_reg},
        {2'b01, 3'b010, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0});
    chk("rst_illegal0", illegal_op, 1'b0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Illegal opcode: ERR after DECODE, no strobes for 10 cycles, reset clears
    opcode = 6'b111111; mem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("err_illegal", illegal_op, 1'b1);
    bad_cyc = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      if ({mem_read, mem_write, ir_write, pc_en, reg_write, instr_done} != 6'b0 || !illegal_op)
        bad_cyc++;
    end
    chk("err_quiet", bad_cyc, 0);
    tick();
    do_reset();
    opcode = 6'b000000; funct = 6'b100000;
    run_vec(vecs[0], 100);

    // Reset asserted during ALU_WB suppresses the write
    opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_wr", {reg_write, instr_done, pc_en, mem_read}, 4'b0);
    tick();
    rst_n = 1'b1;
    run_vec(vecs[1], 101);

    // Opcode 000101 with zero_flag=0
    opcode = 6'b000101; funct = 6'b0; zero_flag = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
`ifdef MC_CTRL_BNE_EN
    chk("bne_taken", {pc_en, pc_src, instr_done, alu_op}, {1'b1, 2'b01, 1'b1, 3'b110});
`else
    chk("bne_illegal", {illegal_op, instr_done, pc_en}, 3'b100);
`endif
    tick();
    do_reset();
    run_vec(vecs[12], 102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
